mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of the shared memory.
REQ-002 SHALL have parameter DATA_W, default 64, meaning memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive denied fetch cycles before fetch is forced.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 if_req_i  in  1  fetch read request; held with a stable if_addr_i until granted.
REQ-008 if_addr_i  in  ADDR_W  fetch word address.
REQ-009 if_flush_i  in  1  fetch flush on branch redirect; cancels a fetch response in flight.
REQ-010 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-011 if_rvalid_o  out  1  fetch read data valid.
REQ-012 if_rdata_o  out  DATA_W  fetch read data.
REQ-013 d_req_i  in  1  data-stage request; held with stable fields until granted.
REQ-014 d_we_i  in  1  1 = write, 0 = read.
REQ-015 d_addr_i  in  ADDR_W  data word address.
REQ-016 d_wdata_i  in  DATA_W  write data.
REQ-017 d_gnt_o  out  1  data request accepted this cycle.
REQ-018 d_rvalid_o  out  1  data read data valid.
REQ-019 d_rdata_o  out  DATA_W  data read data.
REQ-020 mem_en_o  out  1  memory access strobe.
REQ-021 mem_we_o  out  1  memory write strobe.
REQ-022 mem_addr_o  out  ADDR_W  memory address.
REQ-023 mem_wdata_o  out  DATA_W  memory write data.
REQ-024 mem_rdata_i  in  DATA_W  memory read data, valid exactly 1 cycle after mem_en_o with mem_we_o=0.

Function
REQ-025 SHALL grant at most one requester per cycle; if_gnt_o and d_gnt_o are never both 1.
REQ-026 Grants are combinational from requests and the starvation counter; mem_en_o = if_gnt_o | d_gnt_o, and mem_addr_o, mem_we_o and mem_wdata_o are taken from the granted requester in the same cycle.
REQ-027 When neither requester is granted, mem_en_o=0, mem_we_o=0, and mem_addr_o and mem_wdata_o are 0.
REQ-028 Default priority is data over fetch.
REQ-029 Starvation counter (width clog2(STARVE_MAX+1)): +1 each cycle if_req_i=1 and if_gnt_o=0; saturates at STARVE_MAX; cleared on if_gnt_o=1 or if_req_i=0.
REQ-030 When counter = STARVE_MAX and if_req_i=1, fetch wins that cycle even with d_req_i=1.
REQ-031 Response FSM states: IDLE (no read in flight), RSP_IF (fetch read in flight), RSP_D (data read in flight), RSP_KILL (flushed fetch read in flight).
REQ-032 Next state: fetch grant -> RSP_IF, or RSP_KILL if if_flush_i=1 in the grant cycle; data read grant -> RSP_D; data write or no grant -> IDLE.
REQ-033 In RSP_IF, if_flush_i=1 in that cycle converts the response to killed (if_rvalid_o=0).
REQ-034 Transitions occur every cycle regardless of current state, so back-to-back grants are pipelined with no bubble.
REQ-035 In RSP_IF (not flushed), if_rvalid_o=1 and if_rdata_o=mem_rdata_i.
REQ-036 In RSP_D, d_rvalid_o=1 and d_rdata_o=mem_rdata_i.
REQ-037 Otherwise both rvalid outputs are 0 and both rdata outputs are 0.
REQ-038 Read latency is 1 cycle from grant to rvalid.
REQ-039 Writes produce no rvalid.
REQ-040 if_flush_i with no fetch read in flight has no effect.
REQ-041 if_flush_i does not suppress a same-cycle new fetch grant's request acceptance; only that grant's response is killed per REQ-032.

Reset
REQ-042 On rst_i=1 at a clock edge: FSM -> IDLE and starvation counter -> 0.
REQ-043 While rst_i=1, all grant, rvalid, mem_en_o and mem_we_o outputs are 0, and all data and address outputs are 0.
REQ-044 A read granted in the cycle before reset produces no rvalid after reset.

Verification
REQ-045 Only if_req_i=1, addr 0x005, mem returns 0xA5 -> if_gnt_o=1 in cycle 0, if_rvalid_o=1 with if_rdata_o=0xA5 in cycle 1.
REQ-046 if_req_i and d_req_i held 1 continuously, STARVE_MAX=4 -> d_gnt_o in cycles 0-3, if_gnt_o in cycle 4, d_gnt_o in cycle 5.
REQ-047 Data write addr 0x010, wdata 0x1234 with if_req_i=0 -> mem_en_o=1, mem_we_o=1, mem_addr_o=0x010, mem_wdata_o=0x1234; no rvalid next cycle.
REQ-048 Fetch granted in cycle 0, if_flush_i=1 in cycle 1 -> if_rvalid_o=0 in cycle 1; a data read granted in cycle 1 gives d_rvalid_o=1 in cycle 2.
REQ-049 Data read granted, rst_i=1 in the next cycle -> d_rvalid_o=0, counter=0, FSM IDLE.
REQ-050 Alternating fetch/data read grants on consecutive cycles -> each rvalid lands on the correct requester 1 cycle after its grant, with no bubbles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by an instruction-fetch and a data-stage requester.
// Data wins by default; a saturating starvation counter forces fetch through; reads return after 1 cycle.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2,
        RSP_KILL = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             if_gnt, d_gnt;
    logic             starved;

    assign starved = (starve_q == CNT_MAX);

    // Grant decision: data first unless fetch has waited STARVE_MAX cycles; nothing during reset
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst_i) begin
            if (if_req_i && (starved || !d_req_i)) begin
                if_gnt = 1'b1;
            end else if (d_req_i) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign if_gnt_o = if_gnt;
    assign d_gnt_o  = d_gnt;

    // Memory command mux, zeroed when idle
    always_comb begin
        mem_en_o    = if_gnt | d_gnt;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_gnt) begin
            mem_addr_o = if_addr_i;
        end else if (d_gnt) begin
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // Starvation counter: counts consecutive denied fetch cycles, saturating
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Response FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response FSM: next state tracks what this cycle's grant will return next cycle
    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = if_flush_i ? RSP_KILL : RSP_IF;
        end else if (d_gnt && !d_we_i) begin
            state_d = RSP_D;
        end
    end

    // Response FSM: outputs; a flush in the response cycle still kills the fetch data
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        if (!rst_i) begin
            case (state_q)
                RSP_IF: begin
                    if (!if_flush_i) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end
                end
                RSP_D: begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_rdata_i;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we;
    logic [9:0]  if_addr, d_addr;
    logic [63:0] d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [63:0] if_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Memory model; drives garbage when no read was issued
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        else mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
    end

    function automatic logic [63:0] init_word(int a);
        return {32'hC0DE_0000, 32'(a)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 10'h3; d_addr = 10'h4; d_wdata = 64'h55;
        #1;
        total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got %b%b exp 00", if_gnt, d_gnt); end
        total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_en got %b%b exp 00", mem_en, mem_we); end
        total++; if (mem_addr !== 10'h0 || mem_wdata !== 64'h0) begin bad++; $display("FAIL reset_mem_bus got %h %h exp 0 0", mem_addr, mem_wdata); end
        total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 64'h0 || d_rdata !== 64'h0) begin
            bad++; $display("FAIL reset_rsp got %b %b %h %h exp 0", if_rvalid, d_rvalid, if_rdata, d_rdata); end
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        total++; if (mem_en !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got %b %b %b exp 000", mem_en, if_rvalid, d_rvalid); end
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h005; d_req = 1'b0;
        #1;
        total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt got %b%b exp 10", if_gnt, d_gnt); end
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h005) begin
            bad++; $display("FAIL fetch_mem got en=%b we=%b a=%h exp 1 0 005", mem_en, mem_we, mem_addr); end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 64'hA5) begin bad++; $display("FAIL fetch_rsp got %b %h exp 1 a5", if_rvalid, if_rdata); end
        total++; if (d_rvalid !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL fetch_rsp_other got %b %b exp 00", d_rvalid, mem_en); end
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 10'h008;
            d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
            #1;
            total++; if (if_gnt !== (c == 4) || d_gnt !== (c != 4)) begin
                bad++; $display("FAIL starve_gnt c%0d got %b%b exp %b%b", c, if_gnt, d_gnt, c == 4, c != 4); end
            total++; if (mem_addr !== ((c == 4) ? 10'h008 : 10'h020)) begin
                bad++; $display("FAIL starve_addr c%0d got %h", c, mem_addr); end
            if (c == 5) begin
                total++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(8) || d_rvalid !== 1'b0) begin
                    bad++; $display("FAIL starve_if_rsp got %b %h %b", if_rvalid, if_rdata, d_rvalid); end
            end else if (c > 0) begin
                total++; if (d_rvalid !== 1'b1 || d_rdata !== init_word(32) || if_rvalid !== 1'b0) begin
                    bad++; $display("FAIL starve_d_rsp c%0d got %b %h %b", c, d_rvalid, d_rdata, if_rvalid); end
            end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== init_word(32)) begin bad++; $display("FAIL starve_tail got %b %h", d_rvalid, d_rdata); end
        total++; if (mem_en !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 64'h0) begin
            bad++; $display("FAIL idle_bus got %b %h %h exp 0 0 0", mem_en, mem_addr, mem_wdata); end
    endtask

    task automatic test_write();
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 64'h1234;
        #1;
        total++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL write_strobe got %b %b %b exp 111", d_gnt, mem_en, mem_we); end
        total++; if (mem_addr !== 10'h010 || mem_wdata !== 64'h1234) begin
            bad++; $display("FAIL write_bus got %h %h exp 010 1234", mem_addr, mem_wdata); end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== 64'h0) begin
            bad++; $display("FAIL write_no_rvalid got %b %b %h", d_rvalid, if_rvalid, d_rdata); end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        #1;
        total++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL readback_gnt got %b %b", d_gnt, mem_we); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h1234) begin bad++; $display("FAIL readback got %b %h exp 1 1234", d_rvalid, d_rdata); end
    endtask

    task automatic test_flush();
        // flush in the response cycle, data read issued alongside
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h007; d_req = 1'b0;
        #1;
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_fetch_gnt got %b exp 1", if_gnt); end
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        #1;
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 64'h0 || d_gnt !== 1'b1) begin
            bad++; $display("FAIL flush_kill got %b %h %b exp 0 0 1", if_rvalid, if_rdata, d_gnt); end
        @(negedge clk);
        if_flush = 1'b0; d_req = 1'b0;
        #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h1234 || if_rvalid !== 1'b0) begin
            bad++; $display("FAIL flush_d_rsp got %b %h %b", d_rvalid, d_rdata, if_rvalid); end
        // flush in the grant cycle: accepted but killed
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h007; if_flush = 1'b1;
        #1;
        total++; if (if_gnt !== 1'b1 || mem_en !== 1'b1) begin bad++; $display("FAIL flush_same_gnt got %b %b exp 11", if_gnt, mem_en); end
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b0;
        #1;
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_grant_kill got %b exp 0", if_rvalid); end
        // flush with only a data read in flight
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        #1;
        @(negedge clk);
        d_req = 1'b0; if_flush = 1'b1;
        #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h1234) begin bad++; $display("FAIL flush_no_effect got %b %h", d_rvalid, d_rdata); end
        @(negedge clk);
        if_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 10'h008; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_en !== 1'b0) begin
            bad++; $display("FAIL midreset_out got %b %b %b %b exp 0000", d_rvalid, d_gnt, if_gnt, mem_en); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (c == 0) begin
                total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL midreset_rvalid got %b %b exp 00", d_rvalid, if_rvalid); end
            end
            total++; if (if_gnt !== (c == 4) || d_gnt !== (c != 4)) begin
                bad++; $display("FAIL midreset_cnt c%0d got %b%b exp %b%b", c, if_gnt, d_gnt, c == 4, c != 4); end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(8)) begin bad++; $display("FAIL midreset_if_rsp got %b %h", if_rvalid, if_rdata); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h005; d_req = 1'b0;
        #1;
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL b2b_g0 got %b exp 1", if_gnt); end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        #1;
        total++; if (d_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 64'hA5 || d_rvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_c1 got %b %b %h %b", d_gnt, if_rvalid, if_rdata, d_rvalid); end
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'h006; d_req = 1'b0;
        #1;
        total++; if (if_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 64'h1234 || if_rvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_c2 got %b %b %h %b", if_gnt, d_rvalid, d_rdata, if_rvalid); end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(6) || d_rvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_c3 got %b %h %b", if_rvalid, if_rdata, d_rvalid); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        mem[5] = 64'hA5;
        rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_fetch_read();
        test_starvation();
        test_write();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
